// File: rtl/de_timing_decoder_pkg.sv
// Shared types and default geometry for the DE timing decoder and its DE generator sibling.
package de_timing_decoder_pkg;

  localparam int unsigned DEFAULT_BUS_WIDTH = 11;
  localparam int unsigned DEFAULT_RES_H     = 1920;
  localparam int unsigned DEFAULT_RES_V     = 1080;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } fsmStateT;

endpackage

// File: rtl/de_timing_decoder_if.sv
// Video input / recovered-timing bundle between the HDMI receiver side and the decoder.
interface de_timing_decoder_if
  import de_timing_decoder_pkg::*;
#(
  parameter int unsigned busWidth = DEFAULT_BUS_WIDTH
);

  logic                deIn;
  logic                vsyncIn;
  logic                activeOut;
  logic [busWidth-1:0] xOut;
  logic [busWidth-1:0] yOut;
  logic                lineEndOut;
  logic                frameStartOut;
  logic [busWidth-1:0] widthOut;
  logic [busWidth-1:0] heightOut;
  logic                lockedOut;
  logic                errorOut;

  modport master (
    output deIn, vsyncIn,
    input  activeOut, xOut, yOut, lineEndOut, frameStartOut,
    input  widthOut, heightOut, lockedOut, errorOut
  );

  modport slave (
    input  deIn, vsyncIn,
    output activeOut, xOut, yOut, lineEndOut, frameStartOut,
    output widthOut, heightOut, lockedOut, errorOut
  );

endinterface

// File: rtl/de_timing_decoder_sync_edge_detect.sv
// One-cycle history register producing rise/fall strobes for a single-bit input.
module de_timing_decoder_sync_edge_detect #(
  parameter bit resetValue = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic sigIn,
  output logic riseC,
  output logic fallC
);

  logic prev;

  always_ff @(posedge clock) begin
    if (reset) prev <= resetValue;
    else       prev <= sigIn;
  end

  assign riseC = sigIn & ~prev;
  assign fallC = ~sigIn & prev;

endmodule

// File: rtl/de_timing_decoder.sv
// Recovers pixel X/Y from incoming DE/vsync, measures line width and frame height, and tracks lock.
module de_timing_decoder
  import de_timing_decoder_pkg::*;
#(
  parameter int unsigned busWidth      = DEFAULT_BUS_WIDTH,
  parameter int unsigned resHorizontal = DEFAULT_RES_H,
  parameter int unsigned resVertical   = DEFAULT_RES_V
) (
  input logic                clock,
  input logic                reset,
  de_timing_decoder_if.slave bus
);

  logic                deRise, deFall, vsRise, unusedVsFall;
  logic [busWidth-1:0] pixCnt;
  logic                discardLine, lineBad;
  logic                lineDone, widthBad, heightBad;
  logic                lockedC, errorC;
  fsmStateT            state, stateNext;

  function automatic logic [busWidth-1:0] satInc(input logic [busWidth-1:0] v);
    return (v == '1) ? v : v + busWidth'(1);
  endfunction

  de_timing_decoder_sync_edge_detect #(.resetValue(1'b0)) deEdge (
    .clock(clock), .reset(reset), .sigIn(bus.deIn), .riseC(deRise), .fallC(deFall)
  );

  // vsync history starts high so a vsync already asserted at reset release is not a frame start
  de_timing_decoder_sync_edge_detect #(.resetValue(1'b1)) vsEdge (
    .clock(clock), .reset(reset), .sigIn(bus.vsyncIn), .riseC(vsRise), .fallC(unusedVsFall)
  );

  // A line cut by vsync (or ending on the vsync edge) is neither measured nor counted
  assign lineDone  = deFall & ~vsRise & ~discardLine;
  assign widthBad  = lineDone & (pixCnt != busWidth'(resHorizontal));
  assign heightBad = bus.yOut != busWidth'(resVertical);

  always_ff @(posedge clock) begin
    if (reset) state <= SEARCH;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      SEARCH:  if (vsRise) stateNext = MEASURE;
      MEASURE: if (vsRise && !lineBad && !heightBad) stateNext = LOCKED;
      LOCKED:  if (widthBad || (vsRise && heightBad)) stateNext = MEASURE;
      default: stateNext = SEARCH;
    endcase
  end

  always_comb begin
    lockedC = 1'b0;
    errorC  = 1'b0;
    lockedC = (stateNext == LOCKED);
    errorC  = (state == LOCKED) && (stateNext != LOCKED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.activeOut     <= 1'b0;
      bus.xOut          <= '0;
      bus.yOut          <= '0;
      bus.lineEndOut    <= 1'b0;
      bus.frameStartOut <= 1'b0;
      bus.widthOut      <= '0;
      bus.heightOut     <= '0;
      bus.lockedOut     <= 1'b0;
      bus.errorOut      <= 1'b0;
      pixCnt            <= '0;
      discardLine       <= 1'b0;
      lineBad           <= 1'b0;
    end else begin
      bus.activeOut     <= bus.deIn;
      bus.lineEndOut    <= lineDone;
      bus.frameStartOut <= vsRise;
      bus.lockedOut     <= lockedC;
      bus.errorOut      <= errorC;

      // pixCnt runs one ahead of xOut so it equals the line width on the falling edge
      if (bus.deIn) begin
        if (deRise) begin
          bus.xOut <= '0;
          pixCnt   <= busWidth'(1);
        end else begin
          bus.xOut <= pixCnt;
          pixCnt   <= satInc(pixCnt);
        end
      end

      if (lineDone) bus.widthOut <= pixCnt;

      if (vsRise) begin
        bus.heightOut <= bus.yOut;
        bus.yOut      <= '0;
        lineBad       <= 1'b0;
      end else if (lineDone) begin
        bus.yOut <= satInc(bus.yOut);
        if (widthBad) lineBad <= 1'b1;
      end

      if (vsRise)      discardLine <= bus.deIn;
      else if (deRise) discardLine <= 1'b0;
    end
  end

endmodule

// File: tb/tb_de_timing_decoder.sv
// Directed scoreboard bench for de_timing_decoder with an 8x4 target geometry.
module tb_de_timing_decoder;

  localparam int unsigned BW = 11;

  typedef struct {
    logic          act;
    logic [BW-1:0] x, y, w, h;
    logic          le, fs, lk, er;
  } expT;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  expT  sb[$];

  logic [BW-1:0] curX = '0, curY = '0, expW = '0, expH = '0;
  logic          expLock = 1'b0;

  de_timing_decoder_if #(.busWidth(BW)) bus ();

  de_timing_decoder #(.busWidth(BW), .resHorizontal(8), .resVertical(4)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle, queue what the decoder must show after the edge, then compare
  task automatic step(input bit de, input bit vs, input bit le, input bit fs, input bit er);
    expT e, o;
    bus.deIn = de;
    bus.vsyncIn = vs;
    e.act = de; e.x = curX; e.y = curY; e.w = expW; e.h = expH;
    e.le = le; e.fs = fs; e.lk = expLock; e.er = er;
    sb.push_back(e);
    @(posedge clock); #1;
    cyc++;
    o = sb.pop_front();
    chk($sformatf("active@%0d", cyc), 32'(bus.activeOut), 32'(o.act));
    chk($sformatf("x@%0d", cyc), 32'(bus.xOut), 32'(o.x));
    chk($sformatf("y@%0d", cyc), 32'(bus.yOut), 32'(o.y));
    chk($sformatf("lineEnd@%0d", cyc), 32'(bus.lineEndOut), 32'(o.le));
    chk($sformatf("frameStart@%0d", cyc), 32'(bus.frameStartOut), 32'(o.fs));
    chk($sformatf("width@%0d", cyc), 32'(bus.widthOut), 32'(o.w));
    chk($sformatf("height@%0d", cyc), 32'(bus.heightOut), 32'(o.h));
    chk($sformatf("locked@%0d", cyc), 32'(bus.lockedOut), 32'(o.lk));
    chk($sformatf("error@%0d", cyc), 32'(bus.errorOut), 32'(o.er));
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic line(input int n, input bit lossAtEnd);
    for (int i = 0; i < n; i++) begin
      curX = BW'(i);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    curY = curY + BW'(1);
    expW = BW'(n);
    if (lossAtEnd) expLock = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0, lossAtEnd);
  endtask

  task automatic vsync(input bit newLock, input bit deToo);
    bit er;
    er = expLock && !newLock;
    expH = curY;
    curY = '0;
    expLock = newLock;
    if (deToo) curX = '0;
    step(deToo, 1'b1, 1'b0, 1'b1, er);
  endtask

  task automatic frame(input int lines, input bit newLock);
    vsync(newLock, 1'b0);
    gap(2);
    for (int i = 0; i < lines; i++) begin
      line(8, 1'b0);
      gap(2);
    end
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_active"}, 32'(bus.activeOut), 0);
    chk({tag, "_x"}, 32'(bus.xOut), 0);
    chk({tag, "_y"}, 32'(bus.yOut), 0);
    chk({tag, "_lineEnd"}, 32'(bus.lineEndOut), 0);
    chk({tag, "_frameStart"}, 32'(bus.frameStartOut), 0);
    chk({tag, "_width"}, 32'(bus.widthOut), 0);
    chk({tag, "_height"}, 32'(bus.heightOut), 0);
    chk({tag, "_locked"}, 32'(bus.lockedOut), 0);
    chk({tag, "_error"}, 32'(bus.errorOut), 0);
  endtask

  task automatic clearExp();
    curX = '0; curY = '0; expW = '0; expH = '0; expLock = 1'b0;
  endtask

  initial begin
    bus.deIn = 1'b0;
    bus.vsyncIn = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chkAllZero("reset");
    reset = 1'b0;
    gap(3);

    // Acquire: first vsync only enters measurement, second declares lock
    frame(4, 1'b0);
    frame(4, 1'b1);
    chk("acq_height", 32'(bus.heightOut), 4);
    chk("acq_width", 32'(bus.widthOut), 8);
    frame(4, 1'b1);

    // Short line while locked drops lock immediately; relock after a clean frame
    vsync(1'b1, 1'b0);
    gap(2);
    line(8, 1'b0); gap(2);
    line(7, 1'b1);
    chk("short_width", 32'(bus.widthOut), 7);
    chk("short_locked", 32'(bus.lockedOut), 0);
    gap(2);
    line(8, 1'b0); gap(2);
    line(8, 1'b0); gap(2);
    frame(4, 1'b0);
    frame(5, 1'b1);

    // Five-line frame loses lock at its closing vsync
    vsync(1'b0, 1'b0);
    chk("tall_height", 32'(bus.heightOut), 5);
    gap(3);

    // DE already high on the vsync edge: that partial line is discarded
    vsync(1'b0, 1'b1);
    for (int i = 1; i < 8; i++) begin
      curX = BW'(i);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("discard_y", 32'(bus.yOut), 0);
    gap(2);
    line(8, 1'b0);
    gap(2);

    // vsync held high across reset release is not a frame start
    bus.deIn = 1'b0;
    bus.vsyncIn = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chkAllZero("rstvs");
    reset = 1'b0;
    clearExp();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    gap(2);
    for (int i = 0; i < 4; i++) begin
      line(8, 1'b0);
      gap(2);
    end
    frame(4, 1'b0);
    frame(4, 1'b1);
    chk("rstvs_locked", 32'(bus.lockedOut), 1);

    // Reset in the middle of a locked line, then free-running DE without vsync
    for (int i = 0; i < 3; i++) begin
      curX = BW'(i);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    bus.deIn = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chkAllZero("midrst");
    reset = 1'b0;
    clearExp();
    for (int i = 0; i < 3; i++) begin
      line(8, 1'b0);
      gap(2);
    end
    chk("midrst_locked", 32'(bus.lockedOut), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
